// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, reads program memory one word at a time
// and buffers returned words in a prefetch queue for decode. Optional macro: FETCH_PERF_EN.
module fetch_unit #(
  parameter int              DEPTH    = 4,
  parameter int              AW       = 16,
  parameter int              DW       = 16,
  parameter logic [AW-1:0]   RESET_PC = {AW{1'b0}}
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     mem_req,
  output logic [AW-1:0]            mem_addr,
  input  logic                     mem_ack,
  input  logic [DW-1:0]            mem_rdata,
  input  logic                     redirect,
  input  logic [AW-1:0]            redirect_pc,
  output logic                     ir_valid,
  output logic [DW-1:0]            ir_data,
  output logic [AW-1:0]            ir_pc,
  input  logic                     ir_ready,
  output logic [$clog2(DEPTH):0]   q_count
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] L_DEPTH    = (PW+1)'(DEPTH);
  localparam logic [PW:0] L_DEPTH_M1 = (PW+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [AW-1:0]   r_fetch_pc;
  logic [AW-1:0]   w_pc_next;
  logic [AW-1:0]   r_mem_addr;
  logic            r_mem_req;

  logic [DW-1:0]   r_q_data [DEPTH];
  logic [AW-1:0]   r_q_pc   [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [PW:0]     r_count;
  logic [PW:0]     w_count_next;
  logic            w_push;
  logic            w_pop;
  logic            w_ir_valid;

  assign w_ir_valid = (r_count != {(PW+1){1'b0}});
  assign w_push     = (r_state == S_REQ) && mem_ack && !redirect;
  assign w_pop      = w_ir_valid && ir_ready;

  // Queue occupancy after this cycle's push/pop, or zero on a flush.
  always_comb begin
    w_count_next = r_count;
    if (redirect) begin
      w_count_next = {(PW+1){1'b0}};
    end else if (w_push && !w_pop) begin
      w_count_next = r_count + (PW+1)'(1'b1);
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - (PW+1)'(1'b1);
    end else begin
      w_count_next = r_count;
    end
  end

  // Next fetch address and next FSM state.
  always_comb begin
    w_pc_next    = r_fetch_pc;
    w_state_next = r_state;
    if (redirect) begin
      w_pc_next = redirect_pc;
    end else if (w_push) begin
      w_pc_next = r_fetch_pc + AW'(1'b1);
    end else begin
      w_pc_next = r_fetch_pc;
    end

    case (r_state)
      S_IDLE: begin
        if (redirect || (r_count < L_DEPTH)) begin
          w_state_next = S_REQ;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_REQ: begin
        if (redirect) begin
          w_state_next = mem_ack ? S_REQ : S_DRAIN;
        end else if (mem_ack) begin
          // One slot stays free for the request that is about to be issued.
          w_state_next = (w_count_next < L_DEPTH_M1) ? S_REQ : S_IDLE;
        end else begin
          w_state_next = S_REQ;
        end
      end
      S_DRAIN: begin
        // The stale request must complete before a new address can be presented.
        if (mem_ack) begin
          w_state_next = S_REQ;
        end else begin
          w_state_next = S_DRAIN;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // FSM, fetch PC and registered memory-request outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_PC;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_pc_next;
      r_mem_req  <= (w_state_next == S_REQ) || (w_state_next == S_DRAIN);
      if (w_state_next != S_DRAIN) begin
        r_mem_addr <= w_pc_next;
      end
    end
  end

  // Prefetch queue storage and pointers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_head  <= {PW{1'b0}};
      r_tail  <= {PW{1'b0}};
      r_count <= {(PW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_q_data[i] <= {DW{1'b0}};
        r_q_pc[i]   <= {AW{1'b0}};
      end
    end else begin
      r_count <= w_count_next;
      if (redirect) begin
        r_head <= {PW{1'b0}};
        r_tail <= {PW{1'b0}};
      end else begin
        if (w_push) begin
          r_q_data[r_tail] <= mem_rdata;
          r_q_pc[r_tail]   <= r_fetch_pc;
          r_tail           <= r_tail + PW'(1'b1);
        end
        if (w_pop) begin
          r_head <= r_head + PW'(1'b1);
        end
      end
    end
  end

  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;
  assign ir_valid = w_ir_valid;
  assign ir_data  = r_q_data[r_head];
  assign ir_pc    = r_q_pc[r_head];
  assign q_count  = r_count;

`ifdef FETCH_PERF_EN
  logic [15:0] r_stall_cnt;
  logic [1:0]  w_stall_inc;
  logic [16:0] w_stall_sum;

  // Stall contributions: unacked request and empty queue while fetching.
  always_comb begin
    w_stall_inc = {1'b0, r_mem_req & ~mem_ack}
                + {1'b0, ~w_ir_valid & (r_state != S_IDLE)};
    w_stall_sum = {1'b0, r_stall_cnt} + {15'd0, w_stall_inc};
  end

  // Saturating stall counter, cleared by redirect.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt <= 16'h0000;
    end else if (redirect) begin
      r_stall_cnt <= 16'h0000;
    end else if (w_stall_sum[16]) begin
      r_stall_cnt <= 16'hFFFF;
    end else begin
      r_stall_cnt <= w_stall_sum[15:0];
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle tables for streaming, backpressure, redirect,
// PC wrap and mid-request reset, plus a hand-written slow-memory sequence.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        ir_valid;
  logic [15:0] ir_data;
  logic [15:0] ir_pc;
  logic        ir_ready;
  logic [2:0]  q_count;
`ifdef FETCH_PERF_EN
  logic [15:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  fetch_unit #(.DEPTH(4), .AW(16), .DW(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .ir_valid(ir_valid), .ir_data(ir_data),
    .ir_pc(ir_pc), .ir_ready(ir_ready), .q_count(q_count)
`ifdef FETCH_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Program memory contents: a fixed scramble of the address.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  assign mem_rdata = mem_word(mem_addr);

  typedef struct {
    logic        rst_n;
    logic        ack;
    logic        rdy;
    logic        redir;
    logic [15:0] rpc;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_pc;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic a, input logic rd, input logic rr,
                     input logic [15:0] rpc, input logic eq, input logic [15:0] ea,
                     input logic ev, input logic [15:0] ep, input logic [2:0] ec);
    vec_t v;
    v = '{r, a, rd, rr, rpc, eq, ea, ev, ep, ec};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int          exp_pc;
  int          got;
  logic        prev_req;
  logic [15:0] prev_addr;

  initial begin
    reset = 1'b0; mem_ack = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000; ir_ready = 1'b0;

    // Streaming from reset: one word per cycle, first valid two cycles after release.
    add(0,0,0,0,16'h0000, 0,16'h0000,0,16'h0000,3'd0);
    add(1,1,1,0,16'h0000, 1,16'h0000,0,16'h0000,3'd0);
    add(1,1,1,0,16'h0000, 1,16'h0001,1,16'h0000,3'd1);
    add(1,1,1,0,16'h0000, 1,16'h0002,1,16'h0001,3'd1);
    add(1,1,1,0,16'h0000, 1,16'h0003,1,16'h0002,3'd1);
    add(1,1,1,0,16'h0000, 1,16'h0004,1,16'h0003,3'd1);
    // Backpressure: queue fills to 4, then drains in order.
    add(0,0,0,0,16'h0000, 0,16'h0000,0,16'h0000,3'd0);
    add(1,1,0,0,16'h0000, 1,16'h0000,0,16'h0000,3'd0);
    add(1,1,0,0,16'h0000, 1,16'h0001,1,16'h0000,3'd1);
    add(1,1,0,0,16'h0000, 1,16'h0002,1,16'h0000,3'd2);
    add(1,1,0,0,16'h0000, 0,16'h0003,1,16'h0000,3'd3);
    add(1,1,0,0,16'h0000, 1,16'h0003,1,16'h0000,3'd3);
    add(1,1,0,0,16'h0000, 0,16'h0004,1,16'h0000,3'd4);
    add(1,1,0,0,16'h0000, 0,16'h0004,1,16'h0000,3'd4);
    add(1,1,0,0,16'h0000, 0,16'h0004,1,16'h0000,3'd4);
    add(1,1,1,0,16'h0000, 0,16'h0004,1,16'h0001,3'd3);
    add(1,1,1,0,16'h0000, 1,16'h0004,1,16'h0002,3'd2);
    add(1,1,1,0,16'h0000, 1,16'h0005,1,16'h0003,3'd2);
    add(1,1,1,0,16'h0000, 1,16'h0006,1,16'h0004,3'd2);
    add(1,1,1,0,16'h0000, 1,16'h0007,1,16'h0005,3'd2);
    // Redirect to 0x40 while the request for 5 is unacked: drain, then refetch.
    add(0,0,0,0,16'h0000, 0,16'h0000,0,16'h0000,3'd0);
    add(1,1,1,0,16'h0000, 1,16'h0000,0,16'h0000,3'd0);
    add(1,1,1,0,16'h0000, 1,16'h0001,1,16'h0000,3'd1);
    add(1,1,1,0,16'h0000, 1,16'h0002,1,16'h0001,3'd1);
    add(1,1,1,0,16'h0000, 1,16'h0003,1,16'h0002,3'd1);
    add(1,1,1,0,16'h0000, 1,16'h0004,1,16'h0003,3'd1);
    add(1,1,1,0,16'h0000, 1,16'h0005,1,16'h0004,3'd1);
    add(1,0,0,0,16'h0000, 1,16'h0005,1,16'h0004,3'd1);
    add(1,0,0,1,16'h0040, 1,16'h0005,0,16'h0000,3'd0);
    add(1,0,1,0,16'h0000, 1,16'h0005,0,16'h0000,3'd0);
    add(1,1,1,0,16'h0000, 1,16'h0040,0,16'h0000,3'd0);
    add(1,1,1,0,16'h0000, 1,16'h0041,1,16'h0040,3'd1);
    add(1,1,1,0,16'h0000, 1,16'h0042,1,16'h0041,3'd1);
    // Redirect with a same-cycle ack, then PC wrap FFFE -> 0001.
    add(0,0,0,0,16'h0000, 0,16'h0000,0,16'h0000,3'd0);
    add(1,1,1,0,16'h0000, 1,16'h0000,0,16'h0000,3'd0);
    add(1,1,1,1,16'hFFFE, 1,16'hFFFE,0,16'h0000,3'd0);
    add(1,1,1,0,16'h0000, 1,16'hFFFF,1,16'hFFFE,3'd1);
    add(1,1,1,0,16'h0000, 1,16'h0000,1,16'hFFFF,3'd1);
    add(1,1,1,0,16'h0000, 1,16'h0001,1,16'h0000,3'd1);
    add(1,1,1,0,16'h0000, 1,16'h0002,1,16'h0001,3'd1);
    // Reset mid-request with two entries queued, then restart at RESET_PC.
    add(0,0,0,0,16'h0000, 0,16'h0000,0,16'h0000,3'd0);
    add(1,1,0,0,16'h0000, 1,16'h0000,0,16'h0000,3'd0);
    add(1,1,0,0,16'h0000, 1,16'h0001,1,16'h0000,3'd1);
    add(1,1,0,0,16'h0000, 1,16'h0002,1,16'h0000,3'd2);
    add(0,0,0,0,16'h0000, 0,16'h0000,0,16'h0000,3'd0);
    add(1,1,1,0,16'h0000, 1,16'h0000,0,16'h0000,3'd0);
    add(1,1,1,0,16'h0000, 1,16'h0001,1,16'h0000,3'd1);

    for (int k = 0; k < vecs.size(); k++) begin
      reset       = vecs[k].rst_n;
      mem_ack     = vecs[k].ack;
      ir_ready    = vecs[k].rdy;
      redirect    = vecs[k].redir;
      redirect_pc = vecs[k].rpc;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d mem_req", k),  {31'd0, mem_req},  {31'd0, vecs[k].e_req});
      chk($sformatf("row%0d mem_addr", k), {16'd0, mem_addr}, {16'd0, vecs[k].e_addr});
      chk($sformatf("row%0d ir_valid", k), {31'd0, ir_valid}, {31'd0, vecs[k].e_valid});
      chk($sformatf("row%0d q_count", k),  {29'd0, q_count},  {29'd0, vecs[k].e_cnt});
      if (!vecs[k].rst_n) begin
        chk($sformatf("row%0d reset ir_data", k), {16'd0, ir_data}, 32'd0);
        chk($sformatf("row%0d reset ir_pc", k),   {16'd0, ir_pc},   32'd0);
      end else if (vecs[k].e_valid) begin
        chk($sformatf("row%0d ir_pc", k),   {16'd0, ir_pc},   {16'd0, vecs[k].e_pc});
        chk($sformatf("row%0d ir_data", k), {16'd0, ir_data}, {16'd0, mem_word(vecs[k].e_pc)});
      end
    end

    // Slow memory: ack every third cycle; address holds while unacked, delivery in order.
    reset = 1'b0; mem_ack = 1'b0; redirect = 1'b0; ir_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1; ir_ready = 1'b1;
    exp_pc = 0; got = 0; prev_req = mem_req; prev_addr = mem_addr;
    for (int i = 0; i < 30; i++) begin
      mem_ack = ((i % 3) == 2);
      @(posedge clk);
      #1;
      if (prev_req && !mem_ack) begin
        chk($sformatf("slow addr_hold c%0d", i), {16'd0, mem_addr}, {16'd0, prev_addr});
      end
      if (ir_valid) begin
        chk($sformatf("slow ir_pc c%0d", i),   {16'd0, ir_pc},   exp_pc);
        chk($sformatf("slow ir_data c%0d", i), {16'd0, ir_data}, {16'd0, mem_word(16'(exp_pc))});
        exp_pc++;
        got++;
      end
      prev_req  = mem_req;
      prev_addr = mem_addr;
    end
    chk("slow delivered", got, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
